// File: rtl/dso_pkg.sv
// dso_pkg: shared FSM state type and elaboration-time math helpers for the scaled BCD converter
package dso_pkg;
  typedef enum logic [2:0] {IDLE, DIV, BCD, FRAC, DONE} state_t;
  function automatic longint unsigned pow10(input int n);
    pow10 = 1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction
  function automatic int clog2(input longint unsigned v);
    clog2 = 0;
    while ((64'd1 << clog2) < v) clog2++;
  endfunction
endpackage

// File: rtl/serial_divider.sv
// serial_divider: restoring bit-serial divider, one quotient bit per cycle, MSB first
module serial_divider #(
  parameter int W  = 32,
  parameter int RW = 11
) (
  input  logic          CLK,
  input  logic          RSTB,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  quotient,
  output logic [RW-1:0] remainder
);
  localparam int CW = RW > W ? RW : W;
  logic [5:0] cnt;
  logic [RW-1:0] part;
  logic ge;
  // remainder stays below the divisor, so the shifted partial always fits RW bits
  always_comb begin
    part = (remainder << 1) | RW'(quotient[W-1]);
    ge = CW'(part) >= CW'(divisor);
  end
  always_ff @(posedge CLK)
    if (!RSTB) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt <= 6'(W - 1);
      quotient <= dividend;
      remainder <= '0;
    end else begin
      done <= busy && cnt == 6'd0;
      if (busy) begin
        quotient <= {quotient[W-2:0], ge};
        remainder <= ge ? RW'(CW'(part) - CW'(divisor)) : part;
        cnt <= cnt - 6'd1;
        busy <= cnt != 6'd0;
      end
    end
endmodule

// File: rtl/scaled_bcd_converter.sv
// scaled_bcd_converter: DATA_IN / DIVISOR as packed BCD (truncated fraction) with saturation,
// serial datapath with fixed latency 2*DATA_W + 5*FRAC_DIGITS + 1
module scaled_bcd_converter import dso_pkg::*; #(
  parameter int          DATA_W      = 32,
  parameter int unsigned DIVISOR     = 820,
  parameter int          INT_DIGITS  = 1,
  parameter int          FRAC_DIGITS = 4
) (
  input  logic                                 CLK,
  input  logic                                 RSTB,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_W-1:0]                    DATA_IN,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0] DATA_OUT,
  output logic                                 sat
);
  localparam int IW = 4 * INT_DIGITS;
  localparam int FW = FRAC_DIGITS > 0 ? 4 * FRAC_DIGITS : 4;
  localparam int OW = 4 * (INT_DIGITS + FRAC_DIGITS);
  localparam int C = clog2(DIVISOR);
  localparam int RW = C + 1;
  localparam int TW = C + 4;
  localparam longint unsigned QMAX = pow10(INT_DIGITS) - 1;
  localparam logic [IW-1:0] NINES = {INT_DIGITS{4'h9}};
  state_t state;
  logic [5:0] cnt;
  logic [2:0] ph, fdc;
  logic [DATA_W-1:0] q_r, div_q;
  logic [IW-1:0] int_r, adj, int_nx;
  logic [RW-1:0] r_r, div_r;
  logic [TW-1:0] t_r, t_nx, dsh;
  logic [3:0] dig, dig_nx;
  logic [FW-1:0] frac_r, frac_nx;
  logic sat_r, ge, start, div_busy, div_done;
  assign in_ready = state == IDLE;
  assign start = state == IDLE && in_valid;
  serial_divider #(.W(DATA_W), .RW(RW)) u_div (
    .CLK(CLK), .RSTB(RSTB), .start(start), .dividend(DATA_IN), .divisor(DATA_W'(DIVISOR)),
    .busy(div_busy), .done(div_done), .quotient(div_q), .remainder(div_r)
  );
  // double-dabble step on the integer field, and one restoring step of the fractional digit
  always_comb begin
    adj = int_r;
    for (int i = 0; i < INT_DIGITS; i++)
      adj[4*i+:4] = adj[4*i+:4] >= 4'd5 ? adj[4*i+:4] + 4'd3 : adj[4*i+:4];
    int_nx = sat_r && cnt == 6'd0 ? NINES : IW'({adj, q_r[DATA_W-1]});
    dsh = TW'(DIVISOR) << (3'd4 - ph);
    ge = t_r >= dsh;
    t_nx = ge ? t_r - dsh : t_r;
    dig_nx = {dig[2:0], ge};
    frac_nx = (frac_r << 4) | FW'(sat_r ? 4'h9 : dig_nx);
  end
  always_ff @(posedge CLK)
    if (!RSTB) begin
      state <= IDLE;
      cnt <= '0;
      ph <= '0;
      fdc <= '0;
      q_r <= '0;
      int_r <= '0;
      r_r <= '0;
      t_r <= '0;
      dig <= '0;
      frac_r <= '0;
      sat_r <= 1'b0;
      out_valid <= 1'b0;
      DATA_OUT <= '0;
      sat <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          state <= DIV;
          cnt <= 6'(DATA_W - 1);
        end
        DIV: if (div_done && !div_busy) begin
          state <= BCD;
          q_r <= div_q;
          r_r <= div_r;
          sat_r <= 64'(div_q) > QMAX;
          int_r <= '0;
        end
        BCD: begin
          int_r <= int_nx;
          q_r <= q_r << 1;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            if (FRAC_DIGITS == 0) begin
              state <= DONE;
              out_valid <= 1'b1;
              DATA_OUT <= OW'(int_nx);
              sat <= sat_r;
            end else begin
              state <= FRAC;
              ph <= '0;
              fdc <= 3'(FRAC_DIGITS - 1);
              frac_r <= '0;
            end
          end
        end
        FRAC: begin
          ph <= ph == 3'd4 ? 3'd0 : ph + 3'd1;
          if (ph == 3'd0) t_r <= (TW'(r_r) << 3) + (TW'(r_r) << 1);
          else begin
            t_r <= t_nx;
            dig <= dig_nx;
          end
          if (ph == 3'd4) begin
            r_r <= RW'(t_nx);
            frac_r <= frac_nx;
            fdc <= fdc - 3'd1;
            if (fdc == 3'd0) begin
              state <= DONE;
              out_valid <= 1'b1;
              DATA_OUT <= OW'({int_r, frac_nx});
              sat <= sat_r;
            end
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_scaled_bcd_converter.sv
// tb_scaled_bcd_converter: directed scoreboard bench for default and 16-bit/divisor-1 configurations
module tb_scaled_bcd_converter;
  logic CLK = 1'b0, RSTB = 1'b0;
  always #5 CLK = ~CLK;
  logic iv0 = 1'b0, or0 = 1'b0, ir0, ov0, sat0;
  logic [31:0] d0 = '0;
  logic [19:0] o0;
  logic iv1 = 1'b0, or1 = 1'b0, ir1, ov1, sat1;
  logic [15:0] d1 = '0, o1;
  int tests = 0, fails = 0;
  logic [20:0] sb0[$];
  logic [16:0] sb1[$];

  scaled_bcd_converter dut0 (
    .CLK(CLK), .RSTB(RSTB), .in_valid(iv0), .in_ready(ir0), .DATA_IN(d0),
    .out_valid(ov0), .out_ready(or0), .DATA_OUT(o0), .sat(sat0)
  );
  scaled_bcd_converter #(.DATA_W(16), .DIVISOR(1), .INT_DIGITS(4), .FRAC_DIGITS(0)) dut1 (
    .CLK(CLK), .RSTB(RSTB), .in_valid(iv1), .in_ready(ir1), .DATA_IN(d1),
    .out_valid(ov1), .out_ready(or1), .DATA_OUT(o1), .sat(sat1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run0(input logic [31:0] din, input logic [19:0] exp, input logic es);
    logic [20:0] e;
    int n;
    chk("in_ready0 idle", 64'(ir0), 64'(1));
    d0 = din;
    iv0 = 1'b1;
    sb0.push_back({es, exp});
    tick();
    iv0 = 1'b0;
    n = 0;
    while (!ov0 && n < 300) begin
      tick();
      n++;
    end
    chk("latency0", 64'(n), 64'(85));
    chk("sb0 depth", 64'(sb0.size()), 64'(1));
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      chk("data0", 64'(o0), 64'(e[19:0]));
      chk("sat0", 64'(sat0), 64'(e[20]));
    end
  endtask

  task automatic rel0();
    or0 = 1'b1;
    tick();
    or0 = 1'b0;
    chk("out_valid0 drop", 64'(ov0), 64'(0));
    chk("in_ready0 back", 64'(ir0), 64'(1));
  endtask

  task automatic run1(input logic [15:0] din, input logic [15:0] exp, input logic es);
    logic [16:0] e;
    int n;
    chk("in_ready1 idle", 64'(ir1), 64'(1));
    d1 = din;
    iv1 = 1'b1;
    sb1.push_back({es, exp});
    tick();
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 300) begin
      tick();
      n++;
    end
    chk("latency1", 64'(n), 64'(33));
    chk("sb1 depth", 64'(sb1.size()), 64'(1));
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk("data1", 64'(o1), 64'(e[15:0]));
      chk("sat1", 64'(sat1), 64'(e[16]));
    end
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    chk("out_valid1 drop", 64'(ov1), 64'(0));
  endtask

  task automatic quiet0(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (ov0) seen++;
      tick();
    end
    chk(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    tick();
    tick();
    chk("rst out_valid0", 64'(ov0), 64'(0));
    chk("rst data0", 64'(o0), 64'(0));
    chk("rst sat0", 64'(sat0), 64'(0));
    chk("rst in_ready0", 64'(ir0), 64'(1));
    chk("rst out_valid1", 64'(ov1), 64'(0));
    chk("rst data1", 64'(o1), 64'(0));
    RSTB = 1'b1;
    tick();
    run0(32'd1640, 20'h20000, 1'b0);
    rel0();
    run0(32'd1000, 20'h12195, 1'b0);
    rel0();
    run0(32'd8200, 20'h99999, 1'b1);
    rel0();
    run0(32'd8199, 20'h99987, 1'b0);
    rel0();
    run0(32'd2870, 20'h35000, 1'b0);
    rel0();
    run0(32'hFFFF_FFFF, 20'h99999, 1'b1);
    rel0();
    // backpressure: result held, no input taken while DONE
    run0(32'd5741, 20'h70012, 1'b0);
    d0 = 32'd8200;
    for (int i = 0; i < 20; i++) begin
      iv0 = i[0];
      tick();
      chk("bp data0", 64'(o0), 64'h70012);
      chk("bp in_ready0", 64'(ir0), 64'(0));
      chk("bp out_valid0", 64'(ov0), 64'(1));
    end
    iv0 = 1'b1;
    or0 = 1'b1;
    tick();
    iv0 = 1'b0;
    or0 = 1'b0;
    chk("bp release valid", 64'(ov0), 64'(0));
    chk("bp release ready", 64'(ir0), 64'(1));
    quiet0("bp no capture");
    // reset in the middle of the division phase
    d0 = 32'd1640;
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    repeat (9) tick();
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
    chk("abort out_valid0", 64'(ov0), 64'(0));
    chk("abort in_ready0", 64'(ir0), 64'(1));
    quiet0("abort no output");
    run0(32'd0, 20'h00000, 1'b0);
    rel0();
    run1(16'd1234, 16'h1234, 1'b0);
    run1(16'd65535, 16'h9999, 1'b1);
    run1(16'd9999, 16'h9999, 1'b0);
    run1(16'd10000, 16'h9999, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scaled_bcd_converter.md
Name: scaled_bcd_converter

Overview:
- Converts an unsigned binary sample (e.g. accumulated ADC code) into a fixed-point decimal reading: DATA_IN / DIVISOR.
- Output is packed BCD with INT_DIGITS integer digits and FRAC_DIGITS truncated fractional digits, for the display path.
- Uses one shared serial datapath with a valid/ready handshake on both sides, and a fixed, data-independent latency.
- Adds saturation flagging.

Parameters:
- DATA_W, 32, input width in bits (8..32).
- DIVISOR, 820, constant scale divisor (1 .. 2^DATA_W-1).
- INT_DIGITS, 1, integer BCD digits (1..4).
- FRAC_DIGITS, 4, fractional BCD digits (0..6).

Ports:
- CLK  in  1  clock
- RSTB  in  1  synchronous active-low reset
- in_valid  in  1  DATA_IN is valid
- in_ready  out  1  block can accept a sample
- DATA_IN  in  DATA_W  unsigned sample
- out_valid  out  1  DATA_OUT/sat valid
- out_ready  in  1  consumer accepts result
- DATA_OUT  out  4*(INT_DIGITS+FRAC_DIGITS)  packed BCD, most significant integer digit in the MSBs
- sat  out  1  integer part exceeded 10^INT_DIGITS-1

Behaviour:
- Reset and clock: reset RSTB, synchronous, active-low; clock CLK. RSTB low at a CLK edge:
  - state goes to IDLE;
  - out_valid=0, DATA_OUT=0, sat=0, all datapath registers 0;
  - in_ready=1 from the next cycle.
  - Reset mid-operation aborts the conversion with no output.
- State machine: IDLE -> DIV -> BCD -> FRAC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - in_valid at an edge captures DATA_IN and enters DIV with cnt=DATA_W-1.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Remainder register width is clog2(DIVISOR)+1.
  - Runs exactly DATA_W cycles, producing Q (DATA_W bits) and R (R<DIVISOR).
  - On exit: sat_r = (Q > 10^INT_DIGITS-1).
- BCD:
  - Double-dabble of Q into a 4*INT_DIGITS register.
  - Each cycle: add 3 to every nibble >=5, then shift in the next Q bit.
  - Runs exactly DATA_W cycles.
  - If sat_r=1, the integer field is forced to all 9s at the end of BCD.
- FRAC: per fractional digit, 5 cycles:
  - cycle 0: T = R*10 (width clog2(DIVISOR)+4);
  - cycles 1-4: restoring compare/subtract of DIVISOR<<3, <<2, <<1, <<0, giving digit bits d3..d0 (digit <=9 is guaranteed);
  - after cycle 4: remaining T becomes the new R, and the digit is appended.
  - FRAC_DIGITS=0 skips this state.
  - If sat_r=1, fractional digits are forced to 9.
- DONE:
  - out_valid=1; DATA_OUT and sat are stable and held until out_ready=1.
  - An edge with out_ready=1 returns to IDLE and drops out_valid.
- Handshake:
  - in_ready=1 only in IDLE; no input is accepted during DONE, even when out_ready=1 in the same cycle.
  - Back-to-back throughput is one result per L+1 cycles with out_ready tied high.
- Latency: L = 2*DATA_W + 5*FRAC_DIGITS + 1 cycles from the accepting edge to the first cycle out_valid=1. Defaults give L=85.
- Arithmetic:
  - Fractional digits are truncated, never rounded.
  - DATA_IN=0 yields all-zero digits with sat=0.
  - DATA_IN=2^DATA_W-1 is legal.
- Outputs are registered and only change on entry to DONE or at reset.

Decomposition:
- Shared package dso_pkg:
  - state enum (IDLE, DIV, BCD, FRAC, DONE);
  - constant function pow10(n);
  - constant function clog2.
- One sub-module, serial_divider:
  - restoring bit-serial divider (dividend, divisor, start, busy, done, quotient, remainder);
  - used for the DIV phase.
- Double-dabble and FRAC logic stay inline.

Test Plan:
- Exact quotient: defaults, DATA_IN=1640 -> after 85 cycles out_valid=1, DATA_OUT=20'h20000, sat=0.
- Truncation: DATA_IN=1000 -> DATA_OUT=20'h12195 (1.2195...), sat=0.
- Saturation: DATA_IN=8200 -> DATA_OUT=20'h99999, sat=1; DATA_IN=8199 -> 20'h99987, sat=0.
- Backpressure: out_ready held low 20 cycles after out_valid -> DATA_OUT stable, in_ready=0, and in_valid pulses are ignored; out_ready=1 -> out_valid=0 next cycle and in_ready=1.
- Reset mid-DIV: RSTB low at cycle 10 -> out_valid never rises and in_ready=1 after release; a new sample with DATA_IN=0 -> DATA_OUT=0 after exactly 85 cycles.
- Parameter sweep: DATA_W=16, DIVISOR=1, INT_DIGITS=4, FRAC_DIGITS=0, DATA_IN=1234 -> DATA_OUT=16'h1234 after 33 cycles; DATA_IN=65535 -> 16'h9999, sat=1.
